// File: rtl/snake_body_engine.sv
// snake_body_engine: decodes PS/2 direction keys and steps the snake one tile per game tick.
// Optional build macro SNAKE_WRAP_EN: wrap at the board edges instead of ending the game.
module snake_body_engine #(
  parameter int MAX_SEG     = 100,
  parameter int GRID_W      = 10,
  parameter int GRID_H      = 10,
  parameter int START_X     = 4,
  parameter int START_Y     = 4,
  parameter int TICK_CYCLES = 12500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  read_data,
  input  logic                  grow,
  output logic [32*MAX_SEG-1:0] x_values,
  output logic [32*MAX_SEG-1:0] y_values,
  output logic [7:0]            length,
  output logic                  game_done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Direction codes chosen so that the reverse of a heading is heading ^ 1.
  localparam logic [1:0]  D_UP      = 2'd0;
  localparam logic [1:0]  D_DOWN    = 2'd1;
  localparam logic [1:0]  D_LEFT    = 2'd2;
  localparam logic [1:0]  D_RIGHT   = 2'd3;
  localparam logic [31:0] EMPTY     = 32'hFFFF_FFFF;
  localparam logic [31:0] W_LIM     = 32'(GRID_W);
  localparam logic [31:0] H_LIM     = 32'(GRID_H);
  localparam logic [31:0] TICK_LAST = 32'(TICK_CYCLES - 1);
  localparam logic [7:0]  MAX_LEN   = 8'(MAX_SEG);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_x [MAX_SEG];
  logic [31:0] r_y [MAX_SEG];
  logic [7:0]  r_len;
  logic [1:0]  r_dir, r_pend;
  logic        r_grow_pend, r_brk, r_done;
  logic [31:0] r_cnt;

  logic        w_key_vld, w_key_acc, w_move, w_do_grow, w_oob, w_coll;
  logic [1:0]  w_key_dir, w_dir;
  logic [31:0] w_nx, w_ny, w_lim;
  logic [MAX_SEG-1:0] w_hit;

  always_comb begin
    w_key_vld = 1'b0;
    w_key_dir = D_RIGHT;
    case (rx_data)
      8'h1D: begin w_key_vld = 1'b1; w_key_dir = D_UP;    end
      8'h1B: begin w_key_vld = 1'b1; w_key_dir = D_DOWN;  end
      8'h1C: begin w_key_vld = 1'b1; w_key_dir = D_LEFT;  end
      8'h23: begin w_key_vld = 1'b1; w_key_dir = D_RIGHT; end
      default: ;
    endcase
  end

  assign w_key_acc = read_data && !r_brk && w_key_vld && (r_state != S_DONE) &&
                     (w_key_dir != (r_dir ^ 2'b01));
  assign w_move    = (r_state == S_RUN) && (r_cnt == TICK_LAST);
  assign w_dir     = w_key_acc ? w_key_dir : r_pend;
  assign w_do_grow = (r_grow_pend || grow) && (r_len < MAX_LEN);

  always_comb begin
    w_nx  = r_x[0];
    w_ny  = r_y[0];
    w_oob = 1'b0;
    case (w_dir)
      D_UP:    w_ny = r_y[0] - 32'd1;
      D_DOWN:  w_ny = r_y[0] + 32'd1;
      D_LEFT:  w_nx = r_x[0] - 32'd1;
      default: w_nx = r_x[0] + 32'd1;
    endcase
`ifdef SNAKE_WRAP_EN
    if (w_nx == EMPTY)      w_nx = W_LIM - 32'd1;
    else if (w_nx == W_LIM) w_nx = '0;
    if (w_ny == EMPTY)      w_ny = H_LIM - 32'd1;
    else if (w_ny == H_LIM) w_ny = '0;
`else
    w_oob = (w_nx >= W_LIM) || (w_ny >= H_LIM);
`endif
  end

  // The tail slot is only checked when it will still be occupied after the move.
  assign w_lim = w_do_grow ? {24'd0, r_len} : ({24'd0, r_len} - 32'd1);

  for (genvar g = 0; g < MAX_SEG; g++) begin : g_slot
    assign w_hit[g] = (32'(g) < w_lim) && (r_x[g] == w_nx) && (r_y[g] == w_ny);
    assign x_values[32*g +: 32] = r_x[g];
    assign y_values[32*g +: 32] = r_y[g];
  end

  assign w_coll    = w_oob || (|w_hit);
  assign length    = r_len;
  assign game_done = r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_key_acc) w_state_nxt = S_RUN;
      S_RUN:   if (w_move && w_coll) w_state_nxt = S_DONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < MAX_SEG; j++) begin
        r_x[j] <= (j == 0) ? 32'(START_X) : EMPTY;
        r_y[j] <= (j == 0) ? 32'(START_Y) : EMPTY;
      end
      r_len       <= 8'd1;
      r_dir       <= D_RIGHT;
      r_pend      <= D_RIGHT;
      r_grow_pend <= 1'b0;
      r_brk       <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
    end else if (r_state != S_DONE) begin
      if (read_data) begin
        if (r_brk)                r_brk <= 1'b0;
        else if (rx_data == 8'hF0) r_brk <= 1'b1;
      end
      if (w_key_acc) begin
        r_pend <= w_key_dir;
        if (r_state == S_IDLE) r_dir <= w_key_dir;
      end
      if (grow) r_grow_pend <= 1'b1;
      if (r_state == S_RUN) r_cnt <= w_move ? '0 : r_cnt + 32'd1;
      else                  r_cnt <= '0;
      if (w_move) begin
        r_dir       <= w_dir;
        r_pend      <= w_dir;
        r_grow_pend <= 1'b0;
        if (w_coll) begin
          r_done <= 1'b1;
        end else begin
          r_x[0] <= w_nx;
          r_y[0] <= w_ny;
          for (int j = 1; j < MAX_SEG; j++) begin
            if (!w_do_grow && (j == int'(r_len))) begin
              r_x[j] <= EMPTY;
              r_y[j] <= EMPTY;
            end else begin
              r_x[j] <= r_x[j-1];
              r_y[j] <= r_y[j-1];
            end
          end
          if (w_do_grow) r_len <= r_len + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_snake_body_engine.sv
// Scoreboard bench for snake_body_engine: a queue-based snake model predicts the outputs every cycle.
module tb_snake_body_engine;
  localparam int MAX_SEG = 8;
  localparam int TICK    = 4;
  localparam int GW      = 10;
  localparam int GH      = 10;
  localparam int BW      = 32 * MAX_SEG;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          read_data;
  logic          grow;
  logic [BW-1:0] x_values, y_values;
  logic [7:0]    length;
  logic          game_done;

  snake_body_engine #(
    .MAX_SEG(MAX_SEG), .GRID_W(GW), .GRID_H(GH),
    .START_X(4), .START_Y(4), .TICK_CYCLES(TICK)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .read_data(read_data), .grow(grow),
    .x_values(x_values), .y_values(y_values), .length(length), .game_done(game_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] xv;
    logic [BW-1:0] yv;
    logic [7:0]    len;
    logic          done;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: the snake as a list of tiles, head first.
  logic [31:0] sx[$], sy[$];
  bit m_run, m_done, m_brk, m_gp;
  int m_hdx, m_hdy, m_pdx, m_pdy, m_cnt;

  task automatic chk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  function automatic bit key_vec(input logic [7:0] d, output int dx, output int dy);
    dx = 0; dy = 0;
    case (d)
      8'h1D: begin dy = -1; return 1'b1; end
      8'h1B: begin dy =  1; return 1'b1; end
      8'h1C: begin dx = -1; return 1'b1; end
      8'h23: begin dx =  1; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    sx = {32'd4}; sy = {32'd4};
    m_run = 0; m_done = 0; m_brk = 0; m_gp = 0;
    m_hdx = 1; m_hdy = 0; m_pdx = 1; m_pdy = 0; m_cnt = 0;
  endtask

  task automatic model_move();
    logic [31:0] nx, ny;
    bit grew, hit, oob;
    int chk_n;
    m_hdx = m_pdx; m_hdy = m_pdy;
    nx = sx[0] + 32'(m_hdx);
    ny = sy[0] + 32'(m_hdy);
`ifdef SNAKE_WRAP_EN
    if (nx == 32'hFFFF_FFFF) nx = GW - 1; else if (nx == GW) nx = 0;
    if (ny == 32'hFFFF_FFFF) ny = GH - 1; else if (ny == GH) ny = 0;
    oob = 0;
`else
    oob = (nx >= GW) || (ny >= GH);
`endif
    grew  = m_gp && (sx.size() < MAX_SEG);
    chk_n = grew ? sx.size() : sx.size() - 1;
    hit   = 0;
    for (int k = 0; k < chk_n; k++)
      if (sx[k] == nx && sy[k] == ny) hit = 1;
    m_gp = 0;
    if (oob || hit) begin
      m_done = 1; m_run = 0;
    end else begin
      sx.push_front(nx); sy.push_front(ny);
      if (!grew) begin void'(sx.pop_back()); void'(sy.pop_back()); end
    end
  endtask

  task automatic model_step(input bit rstn, input bit rd, input logic [7:0] d, input bit g);
    bit acc;
    int kdx, kdy;
    if (!rstn) begin model_reset(); return; end
    if (m_done) return;
    acc = 0; kdx = 0; kdy = 0;
    if (rd) begin
      if (m_brk) m_brk = 0;
      else if (d == 8'hF0) m_brk = 1;
      else if (key_vec(d, kdx, kdy) && !(kdx == -m_hdx && kdy == -m_hdy)) acc = 1;
    end
    if (g) m_gp = 1;
    if (!m_run) begin
      if (acc) begin
        m_run = 1; m_hdx = kdx; m_hdy = kdy; m_pdx = kdx; m_pdy = kdy; m_cnt = 0;
      end
    end else begin
      if (acc) begin m_pdx = kdx; m_pdy = kdy; end
      if (m_cnt == TICK - 1) begin m_cnt = 0; model_move(); end
      else m_cnt++;
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    for (int j = 0; j < MAX_SEG; j++) begin
      e.xv[32*j +: 32] = (j < sx.size()) ? sx[j] : 32'hFFFF_FFFF;
      e.yv[32*j +: 32] = (j < sy.size()) ? sy[j] : 32'hFFFF_FFFF;
    end
    e.len  = 8'(sx.size());
    e.done = m_done;
    return e;
  endfunction

  task automatic cyc(input bit rstn, input bit rd, input logic [7:0] d, input bit g);
    @(negedge clk);
    reset = rstn; read_data = rd; rx_data = d; grow = g;
    model_step(rstn, rd, d, g);
    exp_q.push_back(snapshot());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 8'h00, 0);
  endtask

  task automatic key(input logic [7:0] d);
    cyc(1, 1, d, 0);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("bus_x", x_values, e.xv);
        chk("bus_y", y_values, e.yv);
        chk("length", BW'(length), BW'(e.len));
        chk("game_done", BW'(game_done), BW'(e.done));
      end
    end
  end

  initial begin : driver
    logic [7:0] tbl [7];
    bit rd, g, rs;
    tbl = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'hF0, 8'h00, 8'h5A};
    reset = 1'b0; read_data = 1'b0; rx_data = 8'h00; grow = 1'b0;
    model_reset();

    do_reset();
    idle(40);
    settle();
    chk("idle_x0", BW'(x_values[31:0]), BW'(4));
    chk("idle_len", BW'(length), BW'(1));

    key(8'hF0); key(8'h23); idle(10);
    settle();
    chk("brk_discard_x0", BW'(x_values[31:0]), BW'(4));
    key(8'h23); idle(12);
    settle();
    chk("run3_x0", BW'(x_values[31:0]), BW'(7));
    chk("run3_y0", BW'(y_values[31:0]), BW'(4));

    key(8'h1C); idle(3);
    settle();
    chk("reverse_ignored_x0", BW'(x_values[31:0]), BW'(8));
    key(8'h1D); idle(3);
    settle();
    chk("up_y0", BW'(y_values[31:0]), BW'(3));

    do_reset();
    key(8'h23);
    for (int i = 0; i < 3; i++) begin cyc(1, 0, 8'h00, 1); idle(3); end
    settle();
    chk("grow_len", BW'(length), BW'(4));
    chk("grow_slot1_x", BW'(x_values[63:32]), BW'(6));
    chk("grow_slot4_x", BW'(x_values[159:128]), BW'(32'hFFFF_FFFF));

    idle(12);
    settle();
`ifdef SNAKE_WRAP_EN
    chk("wall_wrap_x0", BW'(x_values[31:0]), BW'(0));
    chk("wall_wrap_done", BW'(game_done), BW'(0));
`else
    chk("wall_done", BW'(game_done), BW'(1));
    chk("wall_frozen_x0", BW'(x_values[31:0]), BW'(9));
    key(8'h1D); cyc(1, 0, 8'h00, 1); idle(8);
    settle();
    chk("done_keys_x0", BW'(x_values[31:0]), BW'(9));
    chk("done_grow_len", BW'(length), BW'(4));
`endif

    do_reset();
    key(8'h23);
    for (int i = 0; i < 4; i++) begin cyc(1, 0, 8'h00, 1); idle(3); end
    key(8'h1D); idle(3);
    key(8'h1C); idle(3);
    key(8'h1B); idle(3);
    settle();
    chk("self_hit_done", BW'(game_done), BW'(1));
    chk("self_hit_len", BW'(length), BW'(5));
    chk("self_hit_x0", BW'(x_values[31:0]), BW'(7));

    do_reset();
    key(8'h23); idle(5);
    cyc(0, 0, 8'h00, 0);
    #1;
    chk("async_rst_x0", BW'(x_values[31:0]), BW'(4));
    chk("async_rst_len", BW'(length), BW'(1));
    cyc(1, 0, 8'h00, 0);

    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        rd = ($urandom_range(3) == 0) && !(m_run && m_cnt == TICK - 1);
        g  = ($urandom_range(9) == 0);
        rs = ($urandom_range(299) != 0);
        cyc(rs, rd, tbl[$urandom_range(6)], g);
      end
    end

    idle(2);
    settle();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
